// File: rtl/game_controller.sv
// Round sequencer for the guessing game: arms the countdown timer, judges guesses,
// and keeps a saturating BCD score plus a difficulty level that sets the timer load.
module game_controller #(
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int MAX_LEVEL        = 3,
  parameter int MAX_STRIKES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       logged_in,
  input  logic       start_pulse,
  input  logic       guess_pulse,
  input  logic [3:0] userInput,
  input  logic [3:0] rngValue,
  input  logic       timeout,
  output logic       timerReconfig,
  output logic       timerEnable,
  output logic [1:0] gameLevel,
  output logic       rngNext,
  output logic [3:0] scoreTens,
  output logic [3:0] scoreOnes,
  output logic       playing,
  output logic       gameOver
);

  // state | meaning
  // IDLE  | no game; waiting for a logged-in start
  // ARM   | one cycle: reload timer for gameLevel, request new digit
  // PLAY  | timer running, guesses judged
  // HIT   | one cycle: score/level bookkeeping after a correct guess
  // DONE  | game over; score and level held for display
  typedef enum logic [2:0] {IDLE, ARM, PLAY, HIT, DONE} state_t;

  state_t     state, next_state;
  logic [1:0] strikes;
  logic [3:0] hits;
  logic       match;
  logic       new_game;

  assign match    = (userInput == rngValue);
  assign new_game = (state == IDLE || state == DONE) && (next_state == ARM);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_pulse) next_state = ARM;
      ARM:  next_state = PLAY;
      PLAY: begin
        if (timeout)
          next_state = DONE;
        else if (guess_pulse && match)
          next_state = HIT;
        else if (guess_pulse && ({1'b0, strikes} + 3'd1 == 3'(MAX_STRIKES)))
          next_state = DONE;
      end
      HIT:  next_state = ARM;
      DONE: if (start_pulse) next_state = ARM;
      default: next_state = IDLE;
    endcase
    if (!logged_in) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      strikes       <= '0;
      hits          <= '0;
      gameLevel     <= '0;
      scoreTens     <= '0;
      scoreOnes     <= '0;
      timerReconfig <= 1'b0;
      rngNext       <= 1'b0;
      timerEnable   <= 1'b0;
      playing       <= 1'b0;
      gameOver      <= 1'b0;
    end else begin
      state         <= next_state;
      timerReconfig <= (next_state == ARM);
      rngNext       <= (next_state == ARM);
      timerEnable   <= (next_state == PLAY);
      playing       <= (next_state == ARM) || (next_state == PLAY) || (next_state == HIT);
      gameOver      <= (next_state == DONE);

      if (new_game) begin
        strikes   <= '0;
        hits      <= '0;
        gameLevel <= '0;
        scoreTens <= '0;
        scoreOnes <= '0;
      end

      if (state == ARM) strikes <= '0;

      if (state == PLAY && logged_in && !timeout && guess_pulse && !match)
        strikes <= strikes + 2'd1;

      // Bookkeeping is skipped if the player logs out during HIT.
      if (state == HIT && logged_in) begin
        if (!(scoreTens == 4'd9 && scoreOnes == 4'd9)) begin
          if (scoreOnes == 4'd9) begin
            scoreOnes <= 4'd0;
            scoreTens <= scoreTens + 4'd1;
          end else begin
            scoreOnes <= scoreOnes + 4'd1;
          end
        end
        if (hits + 4'd1 == 4'(ROUNDS_PER_LEVEL)) begin
          hits <= '0;
          if (gameLevel != 2'(MAX_LEVEL)) gameLevel <= gameLevel + 2'd1;
        end else begin
          hits <= hits + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus a random action mix, checked against
// a count-based model (score = min(hits,99), level = min(hits/4,3)).
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst, logged_in, start_pulse, guess_pulse, timeout;
  logic [3:0] userInput, rngValue;
  logic       timerReconfig, timerEnable, rngNext, playing, gameOver;
  logic [1:0] gameLevel;
  logic [3:0] scoreTens, scoreOnes;

  int compared   = 0;
  int mismatched = 0;
  int m_hits     = 0;
  int m_strikes  = 0;

  game_controller dut (
    .clk(clk), .rst(rst), .logged_in(logged_in), .start_pulse(start_pulse),
    .guess_pulse(guess_pulse), .userInput(userInput), .rngValue(rngValue),
    .timeout(timeout), .timerReconfig(timerReconfig), .timerEnable(timerEnable),
    .gameLevel(gameLevel), .rngNext(rngNext), .scoreTens(scoreTens),
    .scoreOnes(scoreOnes), .playing(playing), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rec, input logic en,
                         input logic ply, input logic over);
    chk({tag, ".timerReconfig"}, 8'(timerReconfig), 8'(rec));
    chk({tag, ".rngNext"},       8'(rngNext),       8'(rec));
    chk({tag, ".timerEnable"},   8'(timerEnable),   8'(en));
    chk({tag, ".playing"},       8'(playing),       8'(ply));
    chk({tag, ".gameOver"},      8'(gameOver),      8'(over));
  endtask

  task automatic chk_model(input string tag);
    int s, l;
    s = (m_hits > 99) ? 99 : m_hits;
    l = (m_hits / 4 > 3) ? 3 : m_hits / 4;
    chk({tag, ".scoreTens"}, 8'(scoreTens), 8'(s / 10));
    chk({tag, ".scoreOnes"}, 8'(scoreOnes), 8'(s % 10));
    chk({tag, ".gameLevel"}, 8'(gameLevel), 8'(l));
  endtask

  task automatic do_start();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    m_hits = 0;
    m_strikes = 0;
    chk_out("start_arm", 1, 0, 1, 0);
    chk_model("start_arm");
    tick();
    chk_out("start_play", 0, 1, 1, 0);
  endtask

  task automatic do_hit();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    userInput = v;
    rngValue = v;
    guess_pulse = 1'b1;
    tick();
    guess_pulse = 1'b0;
    chk_out("hit_hit", 0, 0, 1, 0);
    chk_model("hit_hit");
    m_hits++;
    m_strikes = 0;
    tick();
    chk_out("hit_arm", 1, 0, 1, 0);
    chk_model("hit_arm");
    tick();
    chk_out("hit_play", 0, 1, 1, 0);
  endtask

  task automatic do_miss();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    rngValue = v;
    userInput = v ^ 4'($urandom_range(1, 15));
    guess_pulse = 1'b1;
    tick();
    guess_pulse = 1'b0;
    m_strikes++;
    if (m_strikes >= 3) chk_out("miss_done", 0, 0, 0, 1);
    else chk_out("miss_play", 0, 1, 1, 0);
    chk_model("miss");
  endtask

  task automatic do_timeout(input bit with_guess);
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    rngValue = v;
    userInput = v;
    guess_pulse = with_guess;
    timeout = 1'b1;
    tick();
    guess_pulse = 1'b0;
    timeout = 1'b0;
    chk_out("timeout_done", 0, 0, 0, 1);
    chk_model("timeout_done");
    tick();
    chk_out("timeout_hold", 0, 0, 0, 1);
    chk_model("timeout_hold");
  endtask

  initial begin
    rst = 1'b0; logged_in = 1'b0; start_pulse = 1'b0; guess_pulse = 1'b0;
    timeout = 1'b0; userInput = '0; rngValue = '0;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 0);
    chk_model("reset");
    rst = 1'b1;
    tick();

    // Async reset mid-PLAY
    logged_in = 1'b1;
    do_start();
    do_hit();
    do_hit();
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    m_hits = 0;
    chk_model("async_rst");
    tick();
    rst = 1'b1;

    // Start ignored while logged out
    logged_in = 1'b0;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    chk_out("no_login", 0, 0, 0, 0);
    tick();
    chk_out("no_login2", 0, 0, 0, 0);

    // Level up, level saturation, score carry and saturation
    logged_in = 1'b1;
    do_start();
    chk("start_level", 8'(gameLevel), 8'd0);
    for (int i = 0; i < 100; i++) do_hit();
    chk("sat_tens", 8'(scoreTens), 8'd9);
    chk("sat_ones", 8'(scoreOnes), 8'd9);
    chk("sat_level", 8'(gameLevel), 8'd3);

    // Three strikes
    do_miss(); do_miss(); do_miss();
    do_start();
    do_hit();
    do_timeout(1'b1);
    do_start();

    // Logout during HIT
    userInput = 4'd5; rngValue = 4'd5;
    guess_pulse = 1'b1;
    tick();
    guess_pulse = 1'b0;
    chk_out("pre_logout_hit", 0, 0, 1, 0);
    logged_in = 1'b0;
    tick();
    chk_out("logout_idle", 0, 0, 0, 0);
    logged_in = 1'b1;
    do_start();

    // Random action mix
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 12);
      if (r < 6) begin
        do_hit();
      end else if (r < 10) begin
        do_miss();
        if (m_strikes >= 3) do_start();
      end else if (r < 12) begin
        tick();
        chk_out("idle_play", 0, 1, 1, 0);
        chk_model("idle_play");
      end else begin
        do_timeout(1'($urandom_range(0, 1)));
        do_start();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
